// File: rtl/md_pkg.sv
// md_pkg: shared funct codes, FSM state encoding, operation class and
// small decode helpers for the MIPS multiply/divide sequencer.
package md_pkg;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    // Any funct this unit responds to (and therefore may stall on).
    function automatic logic is_md_funct(input logic [5:0] f);
        return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                         F_MULT, F_MULTU, F_DIV, F_DIVU};
    endfunction

    // Functs that start a multi-cycle multiply or divide.
    function automatic logic is_muldiv(input logic [5:0] f);
        return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
    endfunction

    // Signed variants take magnitudes and need a sign fix-up at the end.
    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == F_MULT) || (f == F_DIV);
    endfunction

endpackage

// File: rtl/md_seq_if.sv
// md_seq_if: EX-stage request / HI-LO result bundle of the multiply/divide
// sequencer. master = pipeline side, slave = sequencer side.
interface md_seq_if #(
    parameter int WIDTH = 32
);
    logic             MDREQ;
    logic [5:0]       FUNCT;
    logic [WIDTH-1:0] OPA;
    logic [WIDTH-1:0] OPB;
    logic             KILL;
    logic             STALL;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] MDRES;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output MDREQ, FUNCT, OPA, OPB, KILL,
        input  STALL, BUSY, DONE, MDRES, HI, LO
    );

    modport slave (
        input  MDREQ, FUNCT, OPA, OPB, KILL,
        output STALL, BUSY, DONE, MDRES, HI, LO
    );
endinterface

// File: rtl/md_core.sv
// md_core: iterative datapath of the multiply/divide sequencer.
// Radix-2 shift-add multiply and restoring divide on unsigned magnitudes,
// plus the iteration counter that tells the FSM when CALC is finished.
// Optional macro MD_EARLY_TERM_EN: a multiply reports completion as soon
// as the remaining multiplier bits are all zero.
module md_core
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic               i_clk,
    input  logic               i_load,
    input  logic               i_step,
    input  op_e                i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_prod,
    output logic [WIDTH-1:0]   o_quo,
    output logic [WIDTH-1:0]   o_rem,
    output logic               o_last
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic [CNTW-1:0]    r_cnt;

    // Restoring divide: shift the next dividend bit into the remainder and
    // try subtracting the divisor; keep the difference only if non-negative.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvsr};
    assign w_fits  = ~w_diff[WIDTH+1];

    // Load magnitudes on accept, then advance one multiply or divide step per cycle.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_acc   <= '0;
            r_mcand <= {{WIDTH{1'b0}}, i_b};
            r_mplr  <= i_a;
            r_rem   <= '0;
            r_quo   <= i_a;
            r_dvsr  <= i_b;
            r_cnt   <= '0;
        end else if (i_step) begin
            r_cnt <= r_cnt + CNTW'(1);
            if (i_op == OP_MUL) begin
                if (r_mplr[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
            end else begin
                r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_fits};
            end
        end
    end

`ifdef MD_EARLY_TERM_EN
    // The step in this cycle consumes the last set multiplier bit.
    assign o_last = (r_cnt == CNTW'(WIDTH-1)) ||
                    ((i_op == OP_MUL) && (r_mplr[WIDTH-1:1] == '0));
`else
    assign o_last = (r_cnt == CNTW'(WIDTH-1));
`endif

    assign o_prod = r_acc;
    assign o_quo  = r_quo;
    assign o_rem  = r_rem;

endmodule

// File: rtl/md_seq.sv
// md_seq: multi-cycle multiply/divide sequencer beside the EX-stage ALU.
// Owns HI/LO, the IDLE/CALC/FIX FSM, STALL/DONE/BUSY, flush handling and
// the final sign fix-up. Optional macro MD_EARLY_TERM_EN (see md_core).
module md_seq
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic     CLK,
    input  logic     RST,
    md_seq_if.slave  bus
);

    state_e           r_state;
    op_e              r_op;
    logic             r_busy;
    logic             r_done;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_dvz;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic               w_accept;
    logic               w_start;
    logic               w_step;
    logic               w_signed_op;
    logic               w_last;
    logic               w_sign_q;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_mdres;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    // A flush in the same cycle as a request always wins.
    assign w_accept    = (r_state == IDLE) && bus.MDREQ && !bus.KILL;
    assign w_start     = w_accept && is_muldiv(bus.FUNCT);
    assign w_step      = (r_state == CALC) && !bus.KILL;
    assign w_signed_op = is_signed_op(bus.FUNCT);
    assign w_abs_a     = (w_signed_op && bus.OPA[WIDTH-1]) ? neg_w(bus.OPA) : bus.OPA;
    assign w_abs_b     = (w_signed_op && bus.OPB[WIDTH-1]) ? neg_w(bus.OPB) : bus.OPB;

    md_core #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_core (
        .i_clk  (CLK),
        .i_load (w_start),
        .i_step (w_step),
        .i_op   (r_op),
        .i_a    (w_abs_a),
        .i_b    (w_abs_b),
        .o_prod (w_prod),
        .o_quo  (w_quo),
        .o_rem  (w_rem),
        .o_last (w_last)
    );

    // Product and quotient take the xor of the operand signs; remainder follows the dividend.
    assign w_sign_q   = r_sign_a ^ r_sign_b;
    assign w_prod_fix = w_sign_q ? neg_2w(w_prod) : w_prod;
    assign w_quo_fix  = w_sign_q ? neg_w(w_quo)   : w_quo;
    assign w_rem_fix  = r_sign_a ? neg_w(w_rem)   : w_rem;

    // Sequencer FSM with HI/LO writes, BUSY and the one-cycle DONE pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (bus.FUNCT)
                            F_MTHI: r_hi <= bus.OPA;
                            F_MTLO: r_lo <= bus.OPA;
                            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                                r_state  <= CALC;
                                r_busy   <= 1'b1;
                                r_op     <= bus.FUNCT[1] ? OP_DIV : OP_MUL;
                                r_sign_a <= w_signed_op && bus.OPA[WIDTH-1];
                                r_sign_b <= w_signed_op && bus.OPB[WIDTH-1];
                                r_dvz    <= (bus.OPB == '0);
                                r_opa    <= bus.OPA;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (bus.KILL) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_last) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (!bus.KILL) begin
                        r_done <= 1'b1;
                        if (r_op == OP_MUL) begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end else if (r_dvz) begin
                            // Divide by zero returns the raw dividend and an all-ones quotient.
                            r_hi <= r_opa;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // MFHI/MFLO read path, valid in the cycle the move is presented.
    always_comb begin
        w_mdres = '0;
        if (bus.MDREQ && bus.FUNCT == F_MFHI) begin
            w_mdres = r_hi;
        end else if (bus.MDREQ && bus.FUNCT == F_MFLO) begin
            w_mdres = r_lo;
        end
    end

    assign bus.STALL = bus.MDREQ && is_md_funct(bus.FUNCT) && (r_state != IDLE);
    assign bus.BUSY  = r_busy;
    assign bus.DONE  = r_done;
    assign bus.MDRES = w_mdres;
    assign bus.HI    = r_hi;
    assign bus.LO    = r_lo;

endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq: self-checking bench for md_seq. Directed and randomized
// MULT/MULTU/DIV/DIVU traffic checked against a plain-arithmetic model,
// plus HI/LO moves, stall timing, flush and mid-operation reset.
module tb_md_seq;

    localparam int W = 32;

    localparam logic [5:0] MFHI  = 6'h10;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MFLO  = 6'h12;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;

    logic clk = 1'b0;
    logic rst = 1'b1;

    md_seq_if #(.WIDTH(W)) bus();

    md_seq #(.WIDTH(W), .CNTW(6)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.MDREQ = 1'b0;
        bus.FUNCT = 6'h00;
        bus.OPA   = '0;
        bus.OPB   = '0;
        bus.KILL  = 1'b0;
    endtask

    // Architectural result of a mult/div, straight from integer arithmetic.
    function automatic void ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = '0;
        lo = '0;
        if (f == MULT) begin
            p = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (f == MULTU) begin
            up = ua * ub;
            hi = up[63:32];
            lo = up[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (f == DIV) begin
            q = sa / sb;
            r = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            hi = ur[31:0];
            lo = uq[31:0];
        end
    endfunction

    // Cycle (counted from the accept cycle) in which DONE and the new HI/LO appear.
    function automatic int exp_lat(input logic [5:0] f, input logic [31:0] a);
`ifdef MD_EARLY_TERM_EN
        logic [31:0] mag;
        int c;
        if (f == MULT || f == MULTU) begin
            mag = (f == MULT && a[31]) ? (~a + 32'd1) : a;
            c = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) c = i + 1;
            if (c < 1) c = 1;
            return c + 2;
        end
`endif
        return W + 2;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // One mult/div; optionally keep an MFLO pending behind it to exercise STALL.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic follow);
        logic [31:0] eh, el;
        int lat, n, busy_n, stall_n;
        ref_md(f, a, b, eh, el);
        lat = exp_lat(f, a);
        bus.MDREQ = 1'b1; bus.FUNCT = f; bus.OPA = a; bus.OPB = b; bus.KILL = 1'b0;
        #1;
        check({tag, "_stall_idle"}, 32'(bus.STALL), 32'd0);
        cyc();
        if (follow) begin
            bus.FUNCT = MFLO;
            bus.OPA   = $urandom;
        end else begin
            bus.MDREQ = 1'b0;
        end
        #1;
        n = 1; busy_n = 0; stall_n = 0;
        while (!bus.DONE && n < 200) begin
            if (bus.BUSY)  busy_n++;
            if (bus.STALL) stall_n++;
            cyc();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat - 1));
        check({tag, "_busy_at_done"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_hi"}, bus.HI, eh);
        check({tag, "_lo"}, bus.LO, el);
        if (follow) begin
            check({tag, "_stall_cycles"}, 32'(stall_n), 32'(lat - 1));
            check({tag, "_stall_release"}, 32'(bus.STALL), 32'd0);
            check({tag, "_mflo"}, bus.MDRES, el);
        end
        cyc();
        bus.MDREQ = 1'b0;
        check({tag, "_done_pulse"}, 32'(bus.DONE), 32'd0);
        m_hi = eh;
        m_lo = el;
    endtask

    // Start a long MULTU and flush it in cycle k after the accept.
    task automatic kill_at(input string tag, input int k);
        int dn;
        bus.MDREQ = 1'b1; bus.FUNCT = MULTU; bus.OPA = 32'hFFFF_FFFF; bus.OPB = 32'hFFFF_FFFF;
        cyc();
        bus.MDREQ = 1'b0;
        for (int i = 1; i < k; i++) cyc();
        check({tag, "_busy_before"}, 32'(bus.BUSY), 32'd1);
        bus.KILL = 1'b1;
        cyc();
        bus.KILL = 1'b0;
        #1;
        check({tag, "_busy_after"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_hi_kept"}, bus.HI, m_hi);
        check({tag, "_lo_kept"}, bus.LO, m_lo);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.DONE) dn++;
            cyc();
        end
        check({tag, "_no_done"}, 32'(dn), 32'd0);
        check({tag, "_hi_final"}, bus.HI, m_hi);
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] a, b;
        int dn;

        idle_in();
        rst = 1'b1;
        cyc();
        cyc();
        bus.MDREQ = 1'b1; bus.FUNCT = MFLO;
        #1;
        check("rst_busy",  32'(bus.BUSY),  32'd0);
        check("rst_done",  32'(bus.DONE),  32'd0);
        check("rst_hi",    bus.HI,         32'd0);
        check("rst_lo",    bus.LO,         32'd0);
        check("rst_stall", 32'(bus.STALL), 32'd0);
        rst = 1'b0;
        idle_in();

        // HI/LO moves and reads
        bus.MDREQ = 1'b1; bus.FUNCT = MTHI; bus.OPA = 32'h0000_1234;
        cyc();
        bus.FUNCT = MTLO; bus.OPA = 32'hABCD_0000;
        #1;
        check("mthi", bus.HI, 32'h0000_1234);
        cyc();
        check("mtlo", bus.LO, 32'hABCD_0000);
        bus.FUNCT = MFHI; #1;
        check("mfhi", bus.MDRES, 32'h0000_1234);
        bus.FUNCT = MFLO; #1;
        check("mflo", bus.MDRES, 32'hABCD_0000);
        bus.FUNCT = 6'h20; bus.OPA = 32'h5555_5555; #1;
        check("other_mdres", bus.MDRES, 32'd0);
        cyc();
        check("other_busy", 32'(bus.BUSY), 32'd0);
        check("other_hi", bus.HI, 32'h0000_1234);
        idle_in();

        // Directed arithmetic
        run_op("mult_neg",  MULT,  32'hFFFF_FFFE, 32'd3, 1'b1);
        run_op("multu",     MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op("divu",      DIVU,  32'd100, 32'd7, 1'b0);
        run_op("div_neg",   DIV,   32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("div_zero",  DIV,   32'd5, 32'd0, 1'b0);
        run_op("divs_zero", DIV,   32'hFFFF_FFF0, 32'd0, 1'b0);
        run_op("divu_zero", DIVU,  32'h8000_0001, 32'd0, 1'b0);
        run_op("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("multu_5x3", MULTU, 32'd5, 32'd3, 1'b0);
        run_op("mult_zero", MULT,  32'd0, 32'h1234_5678, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 16; i++) begin
            f = MULT + 6'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_op($sformatf("rnd%0d", i), f, a, b, 1'($urandom_range(0, 1)));
        end

        // Flush in CALC and in FIX
        kill_at("kill_calc", 10);
        kill_at("kill_fix", W + 1);

        // Flush together with a request while idle
        bus.MDREQ = 1'b1; bus.FUNCT = MULT; bus.OPA = 32'd7; bus.OPB = 32'd9; bus.KILL = 1'b1;
        cyc();
        check("kill_req_busy", 32'(bus.BUSY), 32'd0);
        bus.FUNCT = MTHI; bus.OPA = 32'hDEAD_BEEF;
        cyc();
        check("kill_mthi_hi", bus.HI, m_hi);
        idle_in();
        cyc();
        check("kill_req_busy2", 32'(bus.BUSY), 32'd0);
        check("kill_req_done",  32'(bus.DONE), 32'd0);

        // Reset in the middle of CALC
        bus.MDREQ = 1'b1; bus.FUNCT = MULTU; bus.OPA = 32'hFFFF_FFFF; bus.OPB = 32'd3;
        cyc();
        bus.MDREQ = 1'b0;
        for (int i = 1; i < 5; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.MDREQ = 1'b1; bus.FUNCT = MFLO;
        #1;
        check("rst_mid_hi",    bus.HI,         32'd0);
        check("rst_mid_lo",    bus.LO,         32'd0);
        check("rst_mid_busy",  32'(bus.BUSY),  32'd0);
        check("rst_mid_done",  32'(bus.DONE),  32'd0);
        check("rst_mid_stall", 32'(bus.STALL), 32'd0);
        idle_in();
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.DONE) dn++;
            cyc();
        end
        check("rst_mid_no_done", 32'(dn), 32'd0);
        m_hi = '0;
        m_lo = '0;

        run_op("after_rst", DIV, 32'hFFFF_FF9C, 32'd7, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
